mem_dump_uart: RTL

//   Debug readout master for the data memory. Drives the datapath's debug address (add) and

---
 rtl/mem_dump_uart_if.sv | 31 +++
 rtl/mem_dump_uart.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_dump_uart_if.sv
// Debug-readout bus between the memory dump UART master and the datapath / board pins.
// The master modport is the dump engine; the slave modport is the datapath/board side.
interface mem_dump_uart_if;
   logic        start;
   logic [31:0] rd_data;
   logic [31:0] add;
   logic        button;
   logic        tx;
   logic        busy;
   logic        done;

   modport master (
      input  start,
      input  rd_data,
      output add,
      output button,
      output tx,
      output busy,
      output done
   );

   modport slave (
      output start,
      output rd_data,
      input  add,
      input  button,
      input  tx,
      input  busy,
      input  done
   );
endinterface

// File: rtl/mem_dump_uart.sv
// Reads NUM_WORDS words from the datapath debug port and streams them MSB byte first
// over an 8N1 UART line. All outputs are registered decodes of the current state.
module mem_dump_uart #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned NUM_WORDS    = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   mem_dump_uart_if.master bus
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_REQ       = 3'd1;
   localparam logic [2:0] S_WAIT      = 3'd2;
   localparam logic [2:0] S_START_BIT = 3'd3;
   localparam logic [2:0] S_DATA      = 3'd4;
   localparam logic [2:0] S_STOP_BIT  = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [WORD_W-1:0] w_q,     w_d;
   logic [1:0]        byte_q,  byte_d;
   logic [2:0]        bit_q,   bit_d;
   logic [BAUD_W-1:0] baud_q,  baud_d;
   logic [31:0]       shift_q, shift_d;
   logic [31:0]       add_q,   add_d;
   logic              button_q, button_d;
   logic              tx_q,     tx_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;

   logic [7:0]        cur_byte;
   logic [WORD_W-1:0] w_inc;
   logic              baud_last;

   assign cur_byte  = shift_q[31:24];
   assign w_inc     = w_q + WORD_W'(1);
   assign baud_last = (baud_q == BAUD_LAST);

   // Next-state and registered-output decode
   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      byte_d   = byte_q;
      bit_d    = bit_q;
      baud_d   = baud_q;
      shift_d  = shift_q;
      add_d    = add_q;
      button_d = (state_q == S_REQ) || (state_q == S_WAIT);
      busy_d   = (state_q != S_IDLE) && (state_q != S_DONE);
      done_d   = (state_q == S_DONE);
      tx_d     = 1'b1;

      if (state_q == S_START_BIT) begin
         tx_d = 1'b0;
      end else if (state_q == S_DATA) begin
         tx_d = cur_byte[bit_q];
      end

      // add is loaded on entry to REQ so a 1-cycle registered memory read is
      // already settled by the time the word is latched leaving WAIT.
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_REQ;
               w_d     = '0;
               add_d   = BASE_ADDR;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            shift_d = bus.rd_data;
            byte_d  = 2'd0;
            bit_d   = 3'd0;
            baud_d  = '0;
            state_d = S_START_BIT;
         end
         S_START_BIT: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
                  state_d = S_STOP_BIT;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_STOP_BIT: begin
            if (baud_last) begin
               baud_d = '0;
               if (byte_q != 2'd3) begin
                  shift_d = {shift_q[23:0], 8'h00};
                  byte_d  = byte_q + 2'd1;
                  state_d = S_START_BIT;
               end else if (w_q != WORD_LAST) begin
                  w_d     = w_inc;
                  add_d   = BASE_ADDR + (32'(w_inc) << 2);
                  state_d = S_REQ;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         w_q      <= '0;
         byte_q   <= 2'd0;
         bit_q    <= 3'd0;
         baud_q   <= '0;
         shift_q  <= 32'h0;
         add_q    <= 32'h0;
         button_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         byte_q   <= byte_d;
         bit_q    <= bit_d;
         baud_q   <= baud_d;
         shift_q  <= shift_d;
         add_q    <= add_d;
         button_q <= button_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.add    = add_q;
   assign bus.button = button_q;
   assign bus.tx     = tx_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule
